// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 3x4 matrix keypad into debounced key levels and press pulses
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk_raw,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [2:0]  row_n,
  output logic [11:0] keystroke,
  output logic [11:0] keypress,
  output logic        scan_tick
);
  localparam int DW = DEB_SCANS > 1 ? $clog2(DEB_SCANS) : 1;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0] r;
  logic [3:0] sync1, col_sync;
  logic [11:0] tog;
  logic smp;
  assign smp = cnt == CW'(SCAN_DIV - 1);
  always_ff @(posedge clk_raw) begin
    if (rst) begin
      cnt <= '0;
      r <= 2'd0;
      row_n <= 3'b110;
      sync1 <= 4'b1111;
      col_sync <= 4'b1111;
      keystroke <= '0;
      keypress <= '0;
      scan_tick <= 1'b0;
    end else begin
      sync1 <= col_n;
      col_sync <= sync1;
      cnt <= smp ? '0 : cnt + 1'b1;
      r <= smp ? (r == 2'd2 ? 2'd0 : r + 2'd1) : r;
      row_n <= smp ? (r == 2'd0 ? 3'b101 : r == 2'd1 ? 3'b011 : 3'b110) : row_n;
      keystroke <= keystroke ^ tog;
      keypress <= tog & ~keystroke;
      scan_tick <= smp && r == 2'd2;
    end
  end
  for (genvar k = 0; k < 12; k++) begin : g_key
    logic [DW-1:0] dc;
    logic hit, diff;
    assign hit = smp && r == 2'(k / 4);
    assign diff = ~col_sync[k % 4] != keystroke[k];
    assign tog[k] = hit && diff && dc == DW'(DEB_SCANS - 1);
    always_ff @(posedge clk_raw) begin
      if (rst || (hit && (!diff || tog[k])))
        dc <= '0;
      else if (hit)
        dc <= dc + 1'b1;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table-driven checks of keypad_scanner with a modelled key matrix
module tb_keypad_scanner;
  logic clk_raw = 1'b0;
  logic rst = 1'b1;
  logic [3:0] col_n;
  logic [2:0] row_n;
  logic [11:0] keystroke, keypress;
  logic scan_tick;
  logic [11:0] pressed = '0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int t;
    int cyc;
    logic [11:0] ks;
    logic [11:0] kp;
  } vec_t;
  vec_t v[$];

  keypad_scanner #(.SCAN_DIV(4), .DEB_SCANS(2)) dut (
    .clk_raw(clk_raw),
    .rst(rst),
    .col_n(col_n),
    .row_n(row_n),
    .keystroke(keystroke),
    .keypress(keypress),
    .scan_tick(scan_tick)
  );

  always #5 clk_raw = ~clk_raw;

  always_comb begin
    col_n = 4'b1111;
    for (int c = 0; c < 4; c++)
      col_n[c] = ~((~row_n[0] & pressed[c]) | (~row_n[1] & pressed[4+c]) | (~row_n[2] & pressed[8+c]));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] press_at(input int t, input int c);
    case (t)
      1, 5: return 12'h020;
      2: return c < 40 ? 12'h020 : 12'h000;
      3: return (c >= 5 && c <= 8) ? 12'h020 : 12'h000;
      4: return 12'h801;
      default: return 12'h000;
    endcase
  endfunction

  task automatic run_test(input int t, input int ncyc);
    logic quiet;
    logic [2:0] exp_row;
    quiet = 1'b1;
    pressed = '0;
    rst = 1'b1;
    @(posedge clk_raw);
    #1;
    rst = 1'b0;
    for (int cyc = 0; cyc <= ncyc; cyc++) begin
      pressed = press_at(t, cyc);
      rst = (t == 5 && cyc == 10);
      @(negedge clk_raw);
      foreach (v[i])
        if (v[i].t == t && v[i].cyc == cyc) begin
          chk($sformatf("t%0d_ks@%0d", t, cyc), 32'(keystroke), 32'(v[i].ks));
          chk($sformatf("t%0d_kp@%0d", t, cyc), 32'(keypress), 32'(v[i].kp));
        end
      if (t == 3 && (keystroke != 0 || keypress != 0))
        quiet = 1'b0;
      if (t == 5 && cyc == 10)
        chk("t5_row_before_rst", 32'(row_n), 32'(3'b011));
      if (t == 5 && cyc == 11)
        chk("t5_row_after_rst", 32'(row_n), 32'(3'b110));
      if (t == 6) begin
        exp_row = ((cyc / 4) % 3) == 0 ? 3'b110 : ((cyc / 4) % 3) == 1 ? 3'b101 : 3'b011;
        chk($sformatf("t6_row@%0d", cyc), 32'(row_n), 32'(exp_row));
        chk($sformatf("t6_onelow@%0d", cyc), $countones(~row_n), 1);
        chk($sformatf("t6_tick@%0d", cyc), 32'(scan_tick), 32'(cyc > 0 && cyc % 12 == 0));
      end
      @(posedge clk_raw);
      #1;
    end
    if (t == 3)
      chk("t3_bounce_quiet", 32'(quiet), 32'(1'b1));
  endtask

  initial begin
    v.push_back('{1, 19, 12'h000, 12'h000});
    v.push_back('{1, 20, 12'h020, 12'h020});
    v.push_back('{1, 21, 12'h020, 12'h000});
    v.push_back('{1, 40, 12'h020, 12'h000});
    v.push_back('{2, 44, 12'h020, 12'h000});
    v.push_back('{2, 55, 12'h020, 12'h000});
    v.push_back('{2, 56, 12'h000, 12'h000});
    v.push_back('{2, 57, 12'h000, 12'h000});
    v.push_back('{4, 15, 12'h000, 12'h000});
    v.push_back('{4, 16, 12'h001, 12'h001});
    v.push_back('{4, 17, 12'h001, 12'h000});
    v.push_back('{4, 23, 12'h001, 12'h000});
    v.push_back('{4, 24, 12'h801, 12'h800});
    v.push_back('{4, 25, 12'h801, 12'h000});
    v.push_back('{5, 19, 12'h000, 12'h000});
    v.push_back('{5, 30, 12'h000, 12'h000});
    v.push_back('{5, 31, 12'h020, 12'h020});
    v.push_back('{5, 32, 12'h020, 12'h000});
    rst = 1'b1;
    repeat (2) @(posedge clk_raw);
    @(negedge clk_raw);
    chk("rst_row", 32'(row_n), 32'(3'b110));
    chk("rst_ks", 32'(keystroke), 32'h0);
    chk("rst_kp", 32'(keypress), 32'h0);
    chk("rst_tick", 32'(scan_tick), 32'h0);
    run_test(1, 45);
    run_test(2, 60);
    run_test(3, 100);
    run_test(4, 30);
    run_test(5, 35);
    run_test(6, 36);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
